// File: rtl/rx_timer.sv
// UART receive bit-timing generator: mid-bit sample strobes per frame,
// plus a frame-complete pulse once the stop bit has been sampled.
module rx_timer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        enable_timer,
  input  logic [13:0] bit_period,
  input  logic [3:0]  data_size,
  output logic        shift_enable,
  output logic        packet_done
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    FINISH,
    HOLD
  } state_t;

  state_t      r_state;
  logic [13:0] r_clk_cnt;
  logic [13:0] r_bp;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_ds;

  logic [13:0] w_mid;
  logic [13:0] w_bp_clamp;
  logic [3:0]  w_ds_clamp;
  logic        w_bit_end;
  logic        w_sample;
  logic        w_last;

  assign w_mid      = r_bp >> 1;
  assign w_bp_clamp = (bit_period < 14'd4) ? 14'd4 : bit_period;
  assign w_ds_clamp = (data_size < 4'd5 || data_size > 4'd8)
                    ? 4'd8 : data_size;

  assign w_bit_end = (r_clk_cnt == r_bp - 14'd1);
  // Start bit (bit_cnt 0) is never sampled.
  assign w_sample  = (r_state == COUNT) && (r_bit_cnt != 4'd0)
                  && (r_clk_cnt == w_mid);
  assign w_last    = w_sample && (r_bit_cnt == r_ds + 4'd1);

  assign shift_enable = enable_timer & w_sample;
  assign packet_done  = enable_timer & (r_state == FINISH);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_bp      <= 14'd4;
      r_ds      <= 4'd8;
    end else if (!enable_timer) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= COUNT;
          r_bp      <= w_bp_clamp;
          r_ds      <= w_ds_clamp;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
        end
        COUNT: begin
          if (w_last) begin
            r_state   <= FINISH;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
          end else if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 14'd1;
          end
        end
        FINISH: r_state <= HOLD;
        HOLD:   r_state <= HOLD;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_timer.sv
// Scoreboard bench for rx_timer: expected pulse cycles are queued
// at frame start and matched against observed strobes.
module tb_rx_timer;

  logic        clk;
  logic        n_rst;
  logic        enable_timer;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        shift_enable;
  logic        packet_done;

  int n_tests;
  int n_fail;
  int g;
  int q[$];

  rx_timer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .bit_period   (bit_period),
    .data_size    (data_size),
    .shift_enable (shift_enable),
    .packet_done  (packet_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) g <= g + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, g);
    end
  endtask

  // Events are encoded as cycle*2 + kind (0 shift, 1 done).
  always @(negedge clk) begin
    while (q.size() > 0 && q[0] < g * 2) begin
      chk("missed", g * 2, q[0]);
      void'(q.pop_front());
    end
    if (shift_enable || packet_done) begin
      chk("excl", int'(shift_enable & packet_done), 0);
      if (q.size() == 0)
        chk("spurious", g * 2 + int'(packet_done), -1);
      else
        chk("event", g * 2 + int'(packet_done), q.pop_front());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Push expected events with frame cycle < lim.
  task automatic start(input int bp, input int ds, input int lim);
    int base, bpe, dse, mid, c;
    bit_period   = 14'(bp);
    data_size    = 4'(ds);
    enable_timer = 1'b1;
    base = g + 1;
    bpe  = (bp < 4) ? 4 : bp;
    dse  = (ds < 5 || ds > 8) ? 8 : ds;
    mid  = bpe / 2;
    for (int k = 1; k <= dse + 1; k++) begin
      c = k * bpe + mid;
      if (c < lim) q.push_back((base + c) * 2);
    end
    c = (dse + 1) * bpe + mid + 1;
    if (c < lim) q.push_back((base + c) * 2 + 1);
  endtask

  task automatic stop(input string tag);
    enable_timer = 1'b0;
    cycles(2);
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    g            = 0;
    n_rst        = 1'b0;
    enable_timer = 1'b0;
    bit_period   = 14'd10;
    data_size    = 4'd8;
    cycles(3);
    chk("rst_se", int'(shift_enable), 0);
    chk("rst_pd", int'(packet_done), 0);
    n_rst = 1'b1;
    cycles(2);

    start(10, 8, 1000);
    cycles(110);
    stop("nominal");

    start(4, 5, 1000);
    cycles(40);
    stop("minimum");

    start(2, 12, 1000);
    cycles(50);
    stop("clamp");

    start(10, 8, 30);
    cycles(31);
    enable_timer = 1'b0;
    cycles(1);
    chk("abort", q.size(), 0);
    start(10, 8, 1000);
    cycles(110);
    stop("restart");

    start(10, 8, 1000);
    cycles(13);
    bit_period = 14'd20;
    cycles(100);
    stop("midchg");
    start(20, 8, 1000);
    cycles(200);
    stop("newbp");

    start(10, 8, 40);
    cycles(41);
    n_rst = 1'b0;
    #1;
    chk("arst_se", int'(shift_enable), 0);
    chk("arst_pd", int'(packet_done), 0);
    cycles(3);
    chk("arst_q", q.size(), 0);
    n_rst = 1'b1;
    start(10, 8, 1000);
    cycles(110);
    stop("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
